// File: rtl/axis_loopback_fifo.sv
// Store-and-forward AXI4-Stream packet FIFO that closes the DMA MM2S -> S2MM loopback.
// Only whole packets are released; a packet longer than the FIFO falls back to cut-through.
module axis_loopback_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                bd_fclk0_125m,
  input  logic                reset_n,
  input  logic                flush,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [ADDR_W:0]     level,
  output logic [31:0]         rx_pkt_cnt,
  output logic [31:0]         tx_pkt_cnt,
  output logic                overflow_cut
);

  localparam int KEEP_W  = DATA_W / 8;
  localparam int ENTRY_W = DATA_W + KEEP_W + 1;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE    = (ADDR_W + 1)'(1);

  typedef enum logic {
    ST_STORE,
    ST_CUT
  } state_t;

  state_t state_q, state_d;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rd_entry;
  logic [ADDR_W:0]    wr_ptr, rd_ptr, pkt_cnt;
  logic               out_of_reset;
  logic               wr_en, rd_en, wr_last, rd_last;

  // s_tready looks only at the registered level, so a full FIFO never takes a beat
  // even when a read frees a slot in the same cycle.
  assign level    = wr_ptr - rd_ptr;
  assign s_tready = out_of_reset && (level != FULL_LEVEL) && !flush;
  assign wr_en    = s_tvalid && s_tready;
  assign wr_last  = wr_en && s_tlast;

  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];
  assign m_tdata  = rd_entry[ENTRY_W-1 -: DATA_W];
  assign m_tkeep  = rd_entry[KEEP_W:1];
  assign m_tlast  = m_tvalid && rd_entry[0];
  assign m_tvalid = (state_q == ST_CUT) ? (level != '0) : (pkt_cnt != '0);
  assign rd_en    = m_tvalid && m_tready && !flush;
  assign rd_last  = rd_en && m_tlast;

  assign overflow_cut = (state_q == ST_CUT);

  always_ff @(posedge bd_fclk0_125m or negedge reset_n) begin
    if (!reset_n) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  always_ff @(posedge bd_fclk0_125m) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {s_tdata, s_tkeep, s_tlast};
    end
  end

  always_ff @(posedge bd_fclk0_125m or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_last, rd_last})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Status counters survive flush; only reset clears them.
  always_ff @(posedge bd_fclk0_125m or negedge reset_n) begin
    if (!reset_n) begin
      rx_pkt_cnt <= '0;
      tx_pkt_cnt <= '0;
    end else begin
      if (wr_last) begin
        rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
      end
      if (rd_last) begin
        tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge bd_fclk0_125m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STORE;
    end else begin
      state_q <= state_d;
    end
  end

  // A full FIFO holding no complete packet can only drain by cut-through.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STORE: begin
        if ((level == FULL_LEVEL) && (pkt_cnt == '0)) begin
          state_d = ST_CUT;
        end
      end
      ST_CUT: begin
        if (rd_last) begin
          state_d = ST_STORE;
        end
      end
      default: state_d = ST_STORE;
    endcase
    if (flush) begin
      state_d = ST_STORE;
    end
  end

endmodule
